// File: rtl/audio_voice_sequencer_if.sv
// Signal bundle between the voice sequencer and its surroundings: the pattern
// ROM, the note-to-increment table, the tick sources and the PWM stage.
//
// Modports:
//   master - the sequencer. It drives pat_addr, note_out, sample_out,
//            sample_valid, step_out, overrun and fsm_state.
//   slave  - the environment. It drives ena, frame_tick, sample_tick,
//            pat_data and inc_in.
//
// Handshake semantics: the two ROM lookups have no handshake. pat_data must
// follow pat_addr, and inc_in must follow note_out, combinationally within
// the same cycle. frame_tick and sample_tick are one-cycle strobes with no
// ready. A strobe that arrives while the same kind of event is still pending
// is dropped and recorded in overrun. sample_valid is a one-cycle strobe with
// no ready. The consumer takes sample_out in that cycle, and sample_out then
// holds until the next strobe.
//
// fsm_state is a debug view of the controller: 0 IDLE, 1 LOAD, 2 ACCUM, 3 OUT.
interface audio_voice_sequencer_if #(
    parameter int NUM_VOICES = 4,
    parameter int STEPS      = 16,
    parameter int PHASE_W    = 16
);
    localparam int SW = $clog2(STEPS);
    localparam int AW = $clog2(STEPS) + $clog2(NUM_VOICES);

    logic               ena;
    logic               frame_tick;
    logic               sample_tick;
    logic [AW-1:0]      pat_addr;
    logic [7:0]         pat_data;
    logic [6:0]         note_out;
    logic [PHASE_W-1:0] inc_in;
    logic [7:0]         sample_out;
    logic               sample_valid;
    logic [SW-1:0]      step_out;
    logic               overrun;
    logic [1:0]         fsm_state;

    modport master (
        input  ena, frame_tick, sample_tick, pat_data, inc_in,
        output pat_addr, note_out, sample_out, sample_valid, step_out,
               overrun, fsm_state
    );

    modport slave (
        output ena, frame_tick, sample_tick, pat_data, inc_in,
        input  pat_addr, note_out, sample_out, sample_valid, step_out,
               overrun, fsm_state
    );
endinterface

// File: rtl/audio_voice_sequencer.sv
// Music sequencer and voice scheduler.
//
// On frame ticks the block counts frames and advances through a pattern of
// STEPS steps. At each step it reads one ROM word per voice: gate in bit 7
// and note in bits 6:0. For each note it latches the phase increment that
// the external table returns.
//
// On sample ticks one accumulator/mixer datapath is shared across all the
// voices, one voice per cycle. The block then emits one 8-bit mixed sample.
//
// Ports:
//   clk, rst_n - single clock; asynchronous active-low reset
//   bus        - audio_voice_sequencer_if.master (ROM bus, ticks, sample out)
module audio_voice_sequencer #(
    parameter int NUM_VOICES     = 4,
    parameter int STEPS          = 16,
    parameter int TICKS_PER_STEP = 8,
    parameter int PHASE_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    audio_voice_sequencer_if.master bus
);
    localparam int VW  = $clog2(NUM_VOICES);
    localparam int SW  = $clog2(STEPS);
    localparam int FCW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(TICKS_PER_STEP - 1);
    localparam logic [VW-1:0]  V_LAST  = VW'(NUM_VOICES - 1);
    // NUM_VOICES * AMP <= 255, so the 8-bit mix can never wrap.
    localparam logic [7:0]     AMP     = 8'(255 / NUM_VOICES);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACCUM = 2'd2, OUT = 2'd3} state_t;

    state_t                state, state_nx;
    logic [VW-1:0]         v;
    logic [SW-1:0]         step;
    logic [FCW-1:0]        frame_cnt;
    logic                  load_pend, samp_pend;
    logic [PHASE_W-1:0]    phase [NUM_VOICES];
    logic [PHASE_W-1:0]    inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate;
    logic [7:0]            mix, sample_q;
    logic                  sample_valid_q, overrun_q;

    logic samp_evt, step_evt, last_voice, start_accum, start_load;

    assign samp_evt   = bus.ena & bus.sample_tick;
    // A step completes on the frame tick that closes the current step.
    assign step_evt   = bus.ena & bus.frame_tick & (frame_cnt == FC_LAST);
    assign last_voice = (v == V_LAST);

    // A sample tick that arrives in IDLE is taken at once, without passing
    // through samp_pend. This keeps the latency at NUM_VOICES+2 cycles.
    always_comb begin
        state_nx    = state;
        start_accum = 1'b0;
        start_load  = 1'b0;
        if (!bus.ena) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (samp_pend || samp_evt) begin
                        state_nx    = ACCUM;
                        start_accum = 1'b1;
                    end else if (load_pend) begin
                        state_nx   = LOAD;
                        start_load = 1'b1;
                    end
                end
                LOAD:    if (last_voice) state_nx = IDLE;
                ACCUM:   if (last_voice) state_nx = OUT;
                OUT:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step           <= '0;
            frame_cnt      <= '0;
            load_pend      <= 1'b1;   // load step 0 right after reset
            samp_pend      <= 1'b0;
            overrun_q      <= 1'b0;
            v              <= '0;
            mix            <= '0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            gate           <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= '0;
            end
        end else if (!bus.ena) begin
            // Halted: drop pending work and keep the voice state as it is.
            load_pend      <= 1'b0;
            samp_pend      <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            // A second event of the same kind while one is pending is lost.
            samp_pend <= (samp_pend | samp_evt) & ~start_accum;
            load_pend <= (load_pend | step_evt) & ~start_load;
            overrun_q <= overrun_q | (samp_evt & samp_pend) | (step_evt & load_pend);

            // The step counter runs independently of the FSM.
            if (bus.frame_tick) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    step      <= step + SW'(1);
                end else begin
                    frame_cnt <= frame_cnt + FCW'(1);
                end
            end

            if (start_accum) begin
                v   <= '0;
                mix <= '0;
            end else if (start_load) begin
                v <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        gate[v] <= bus.pat_data[7];
                        inc[v]  <= bus.inc_in;
                        v       <= v + VW'(1);
                    end
                    ACCUM: begin
                        // The mix uses the MSB before this update. Ungated
                        // voices still advance their phase.
                        phase[v] <= phase[v] + inc[v];
                        if (gate[v] && phase[v][PHASE_W-1]) mix <= mix + AMP;
                        v <= v + VW'(1);
                    end
                    OUT: begin
                        sample_q       <= mix;
                        sample_valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.pat_addr     = {step, v};
    assign bus.note_out     = bus.pat_data[6:0];
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = sample_valid_q;
    assign bus.step_out     = step;
    assign bus.overrun      = overrun_q;
    assign bus.fsm_state    = state;
endmodule

// File: tb/tb_audio_voice_sequencer.sv
// Testbench for audio_voice_sequencer.
//
// The bench models the external pattern ROM and the increment table with
// arrays. It compares each emitted sample against a reference model of the
// voices, which keeps integer phases, increments and gates per voice.
module tb_audio_voice_sequencer;
    localparam int NV  = 4;
    localparam int ST  = 16;
    localparam int TPS = 8;
    localparam int PW  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    audio_voice_sequencer_if #(.NUM_VOICES(NV), .STEPS(ST), .PHASE_W(PW)) bus ();

    audio_voice_sequencer #(
        .NUM_VOICES(NV), .STEPS(ST), .TICKS_PER_STEP(TPS), .PHASE_W(PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- external ROMs ----------------
    logic [7:0]  rom     [ST*NV];
    logic [15:0] inc_tbl [128];
    assign bus.pat_data = rom[bus.pat_addr];
    assign bus.inc_in   = inc_tbl[bus.note_out];

    // ---------------- reference model ----------------
    int m_phase [NV];
    int m_inc   [NV];
    bit m_gate  [NV];
    int m_step;
    int m_fcnt;

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_phase[i] = 0;
            m_inc[i]   = 0;
            m_gate[i]  = 1'b0;
        end
        m_step = 0;
        m_fcnt = 0;
    endfunction

    function automatic void model_load();
        logic [7:0] w;
        for (int i = 0; i < NV; i++) begin
            w          = rom[m_step*NV + i];
            m_gate[i]  = w[7];
            m_inc[i]   = int'(inc_tbl[w[6:0]]);
        end
    endfunction

    // Returns 1 when this frame completes a step.
    function automatic bit model_frame();
        m_fcnt++;
        if (m_fcnt == TPS) begin
            m_fcnt = 0;
            m_step = (m_step + 1) % ST;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // A voice contributes 255/NV while its phase is in the upper half.
    function automatic logic [7:0] model_sample();
        int acc;
        acc = 0;
        for (int i = 0; i < NV; i++) begin
            if (m_gate[i] && m_phase[i] >= (1 << (PW-1))) acc += 255 / NV;
            m_phase[i] = (m_phase[i] + m_inc[i]) % (1 << PW);
        end
        return 8'(acc);
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] last_exp = 8'h00;
    logic [7:0] mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n && bus.sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample_valid", 32'(bus.sample_valid), 32'd0);
            end else begin
                mon_e    = exp_q.pop_front();
                last_exp = mon_e;
                check("sample_out", 32'(bus.sample_out), 32'(mon_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle tick(s). With upd set, the model takes the event the way the
    // DUT should: the sample first, then the step reload.
    task automatic pulse(input bit f, input bit s, input bit upd);
        if (upd) begin
            if (s) exp_q.push_back(model_sample());
            if (f && model_frame()) model_load();
        end
        @(negedge clk);
        bus.frame_tick  = f;
        bus.sample_tick = s;
        @(posedge clk);
        #1;
        bus.frame_tick  = 1'b0;
        bus.sample_tick = 1'b0;
    endtask

    // A sample tick (optionally with a frame tick) from IDLE. This checks the
    // tick-to-valid latency and, when lit >= 0, the value against a constant.
    task automatic sample_timed(input bit f, input int lit);
        int lat;
        bit seen;
        exp_q.push_back(model_sample());
        if (f && model_frame()) model_load();
        @(negedge clk);
        bus.sample_tick = 1'b1;
        bus.frame_tick  = f;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            bus.sample_tick = 1'b0;
            bus.frame_tick  = 1'b0;
            lat++;
            if (bus.sample_valid) seen = 1'b1;
        end
        check("sample_latency", 32'(lat), 32'(NV + 2));
        if (lit >= 0) check("sample_value", 32'(bus.sample_out), 32'(lit));
    endtask

    // Expects one LOAD: pat_addr walks base..base+NV-1 on consecutive cycles,
    // starting with the next clock edge, with no sample_valid.
    task automatic check_load(input int base);
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            check("load_pat_addr", 32'(bus.pat_addr), 32'(base + i));
            check("load_no_valid", 32'(bus.sample_valid), 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.ena         = 1'b1;
        bus.frame_tick  = 1'b0;
        bus.sample_tick = 1'b0;
        for (int i = 0; i < ST*NV; i++) rom[i] = 8'h80 | 8'(i % NV);
        for (int i = 0; i < 128; i++) inc_tbl[i] = 16'h8000;
        model_reset();

        // reset state
        idle(3);
        check("rst_sample_out", 32'(bus.sample_out), 32'd0);
        check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_step_out", 32'(bus.step_out), 32'd0);
        check("rst_pat_addr", 32'(bus.pat_addr), 32'd0);
        check("rst_fsm_idle", 32'(bus.fsm_state), 32'd0);

        // release: step 0 is loaded first
        @(negedge clk);
        rst_n = 1'b1;
        model_load();
        check_load(0);
        check("init_step_out", 32'(bus.step_out), 32'd0);
        idle(10);

        // square waves at half rate, all gated: 0,252,0,252
        sample_timed(1'b0, 0);   idle(14);
        sample_timed(1'b0, 252); idle(14);
        sample_timed(1'b0, 0);   idle(14);
        sample_timed(1'b0, 252); idle(14);

        // step advance after TPS frames, then wrap after ST*TPS frames
        for (int i = 0; i < TPS-1; i++) begin pulse(1'b1, 1'b0, 1'b1); idle(7); end
        check("step_before_edge", 32'(bus.step_out), 32'd0);
        pulse(1'b1, 1'b0, 1'b1);
        check("step_after_edge", 32'(bus.step_out), 32'd1);
        check_load(NV);
        idle(6);
        for (int i = 0; i < ST*TPS - TPS; i++) begin pulse(1'b1, 1'b0, 1'b1); idle(7); end
        check("step_wrap", 32'(bus.step_out), 32'd0);

        // frame (completing a step) and sample together: the sample must use
        // the old gates, and step 1 (now ungated) is loaded afterwards
        for (int i = 0; i < NV; i++) rom[NV + i] = 8'h05;
        sample_timed(1'b0, 0); idle(14);
        for (int i = 0; i < TPS-1; i++) begin pulse(1'b1, 1'b0, 1'b1); idle(7); end
        sample_timed(1'b1, 252);
        check_load(NV);
        check("combined_overrun", 32'(bus.overrun), 32'd0);
        check("combined_step", 32'(bus.step_out), 32'd1);
        idle(6);
        sample_timed(1'b0, 0); idle(14);

        // overrun: the second tick queues, the third is dropped
        pulse(1'b0, 1'b1, 1'b1);
        pulse(1'b0, 1'b1, 1'b1);
        check("overrun_after_queue", 32'(bus.overrun), 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check("overrun_set", 32'(bus.overrun), 32'd1);
        idle(30);
        check("overrun_sticky", 32'(bus.overrun), 32'd1);

        // ena=0: ticks ignored, state frozen, output held
        @(negedge clk);
        bus.ena = 1'b0;
        for (int i = 0; i < 3; i++) begin pulse(1'b1, 1'b1, 1'b0); idle(4); end
        check("halt_step", 32'(bus.step_out), 32'(m_step));
        check("halt_sample_hold", 32'(bus.sample_out), 32'(last_exp));
        check("halt_no_valid", 32'(bus.sample_valid), 32'd0);
        @(negedge clk);
        bus.ena = 1'b1;
        idle(4);

        // randomized pattern, increments and tick mix
        for (int i = 0; i < ST*NV; i++) rom[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 128; i++) inc_tbl[i] = 16'($urandom);
        for (int slot = 0; slot < 240; slot++) begin
            int r;
            r = $urandom_range(0, 9);
            pulse(r >= 4, r <= 5, 1'b1);
            idle(14);
            check("rand_step", 32'(bus.step_out), 32'(m_step));
            if (slot == 120) begin
                for (int i = 0; i < ST*NV; i++) rom[i] = 8'($urandom_range(0, 255));
            end
        end
        check("overrun_still_set", 32'(bus.overrun), 32'd1);

        // asynchronous reset in the middle of ACCUM
        pulse(1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        model_reset();
        #1;
        check("midrst_sample_out", 32'(bus.sample_out), 32'd0);
        check("midrst_sample_valid", 32'(bus.sample_valid), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        check("midrst_step_out", 32'(bus.step_out), 32'd0);
        check("midrst_pat_addr", 32'(bus.pat_addr), 32'd0);
        idle(3);
        rst_n = 1'b1;
        model_load();
        check_load(0);
        idle(8);
        sample_timed(1'b0, 0);

        // drain the scoreboard
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/audio_voice_sequencer.md
Name: audio_voice_sequencer

Overview:
- Music sequencer and voice scheduler for the audio demo top level.
- On frame ticks from the VGA timing it steps through an external pattern ROM and configures per-voice phase increments.
- On sample ticks it time-shares one phase-accumulator/mixer datapath across all voices and emits one 8-bit mixed sample for the PWM output stage.

Parameters:
- NUM_VOICES, 4, voice count; power of 2, 2..8.
- STEPS, 16, pattern length in steps; power of 2.
- TICKS_PER_STEP, 8, frame ticks per pattern step; >=1.
- PHASE_W, 16, phase accumulator width per voice.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  design enable; 0 = sequencer halted.
- frame_tick  in  1  one-cycle pulse per video frame.
- sample_tick  in  1  one-cycle pulse per audio sample period.
- pat_addr  out  log2(STEPS)+log2(NUM_VOICES)  pattern ROM address = {step, voice}.
- pat_data  in  8  combinational ROM word: [7] gate, [6:0] note.
- note_out  out  7  note index to the external increment table (= pat_data[6:0]).
- inc_in  in  PHASE_W  combinational phase increment for note_out.
- sample_out  out  8  mixed sample, registered.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- step_out  out  log2(STEPS)  current pattern step.
- overrun  out  1  sticky flag: a tick arrived while the same tick type was already pending.

Behaviour:
- Reset: state IDLE; step=0; frame_cnt=0; all phase, inc and gate registers =0; sample_out=0; sample_valid=0; overrun=0; pat_addr=0; load_pend=1, so step 0 is loaded after reset; samp_pend=0.
- Frame counting: each frame_tick increments frame_cnt.
  - At TICKS_PER_STEP-1, frame_cnt wraps to 0, step increments (STEPS-1 wraps to 0) and load_pend is set.
  - Steps advance even while the FSM is busy.
- sample_tick sets samp_pend.
- Setting a pending flag that is already 1 sets overrun; the extra event is dropped.
- FSM states: IDLE, LOAD, ACCUM, OUT.
- IDLE:
  - If samp_pend: go to ACCUM, v=0, mix=0, clear samp_pend.
  - Else if load_pend: go to LOAD, v=0, clear load_pend.
  - Sample has priority over load.
- LOAD, one cycle per voice:
  - pat_addr={step,v}; note_out=pat_data[6:0].
  - Latch gate[v]=pat_data[7] and inc[v]=inc_in.
  - After v=NUM_VOICES-1, go to IDLE.
  - Takes NUM_VOICES cycles; never interrupted.
- ACCUM, one cycle per voice:
  - phase[v] <= phase[v]+inc[v], mod 2^PHASE_W.
  - mix += (gate[v] & phase[v][PHASE_W-1]) ? AMP : 0, where AMP=255/NUM_VOICES (integer). The pre-update MSB is used.
  - After the last voice, go to OUT.
- OUT: sample_out<=mix; sample_valid=1 for this cycle only; go to IDLE.
- mix width: 8 bits; it cannot overflow because NUM_VOICES*AMP<=255.
- Latency: sample_tick accepted in IDLE at cycle t gives sample_valid at t+NUM_VOICES+2 (entry, NUM_VOICES ACCUM cycles, OUT).
- Ungated voices still advance phase but contribute 0.
- Simultaneous frame_tick and sample_tick: both flags are set; the sample is serviced first, then LOAD.
- ena=0:
  - Synchronously forces IDLE and clears both pending flags and sample_valid.
  - Ticks are ignored; frame_cnt and step freeze.
  - phase, inc, gate and sample_out are retained.
  - On re-enable, the next step change triggers a reload.
- Reset mid-LOAD or mid-ACCUM: async reset to the reset values above, including load_pend=1.

Test Plan:
- Reset release, ena=1, ROM word 0x80|voice → LOAD runs 4 cycles with pat_addr 0,1,2,3; step_out=0; no sample_valid.
- inc_in=0x8000, all gates 1, 4 sample_ticks spaced 20 cycles → MSBs pre-update 0,1,0,1 → sample_out 0,252,0,252; sample_valid exactly 6 cycles after each tick.
- 8 frame_ticks → step_out=1, LOAD with pat_addr 4..7; 128 frame_ticks → step wraps to 0.
- frame_tick (completing a step) and sample_tick in the same cycle → ACCUM precedes LOAD; sample uses old increments; overrun stays 0.
- Two sample_ticks while ACCUM is busy → second sets samp_pend, third sets overrun=1; overrun stays 1 until reset.
- Assert rst_n low during ACCUM → all outputs 0 immediately; after release, LOAD of step 0 first.
